restoring_divider: RTL and testbench



---
 rtl/restoring_divider.sv | 120 ++++++++++++
 tb/tb_restoring_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: dividend loaded into Q, divisor latched on Execute,
// one SHIFT/SUB pair per quotient bit, quotient left in Q and remainder in R.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             ClearR_LoadQ,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSub,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH:0]    r_q, r_d;   // extra bit holds the post-shift carry for the compare
    logic [WIDTH-1:0]  d_q, d_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dbz_q, dbz_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update; every register holds unless a state changes it
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                // Execute takes priority over a simultaneous load
                if (Execute) begin
                    d_d   = Din;
                    r_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (Din != '0) begin
                        state_d = StShift;
                    end else begin
                        dbz_d   = 1'b1;
                        r_d     = {1'b0, q_q};
                        q_d     = '1;
                        state_d = StDone;
                    end
                end else if (ClearR_LoadQ) begin
                    q_d   = Din;
                    r_d   = '0;
                    dbz_d = 1'b0;
                end
            end
            StShift: begin
                // R stays below D before the shift, so its top bit is always zero here
                r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = {q_q[WIDTH-2:0], 1'b0};
                state_d = StSub;
            end
            StSub: begin
                if (r_q >= {1'b0, d_q}) begin
                    r_d    = r_q - {1'b0, d_q};
                    q_d[0] = 1'b1;
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = StShift;
                end
            end
            StDone: begin
                // Wait for button release so a held Execute runs only once
                if (!Execute) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status and result outputs decoded straight from registers
    always_comb begin
        Busy      = (state_q == StShift) || (state_q == StSub);
        Done      = (state_q == StDone);
        Quotient  = q_q;
        Remainder = r_q[WIDTH-1:0];
        DivByZero = dbz_q;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random divides against an
// arithmetic reference model (plain / and %).
module tb_restoring_divider;

    localparam int unsigned WIDTH = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Execute;
    logic             ClearR_LoadQ;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // Reference model state
    int unsigned m_q   = 0;
    int unsigned m_r   = 0;
    int unsigned m_dbz = 0;

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Execute     (Execute),
        .ClearR_LoadQ(ClearR_LoadQ),
        .Din         (Din),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge; inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_results(input string tag);
        check({tag, ".quot"}, 32'(Quotient), m_q);
        check({tag, ".rem"}, 32'(Remainder), m_r);
        check({tag, ".dbz"}, 32'(DivByZero), m_dbz);
    endtask

    task automatic load(input int unsigned v);
        ClearR_LoadQ = 1'b1;
        Din          = WIDTH'(v);
        tick();
        ClearR_LoadQ = 1'b0;
        m_q   = v;
        m_r   = 0;
        m_dbz = 0;
    endtask

    // Press Execute with divisor d, keep it held for hold cycles after Done, then release.
    // With disturb set, Din and ClearR_LoadQ are scrambled while the divider is busy.
    task automatic divide(input string tag, input int unsigned d, input int unsigned hold,
                          input bit disturb);
        int unsigned edges;
        int unsigned busy_cycles;
        Execute = 1'b1;
        Din     = WIDTH'(d);
        if (d == 0) begin
            m_r   = m_q;
            m_q   = (1 << WIDTH) - 1;
            m_dbz = 1;
        end else begin
            m_r   = m_q % d;
            m_q   = m_q / d;
            m_dbz = 0;
        end
        tick();
        edges       = 1;
        busy_cycles = 0;
        while (!Done && edges < 100) begin
            if (Busy) busy_cycles++;
            if (disturb) begin
                Din          = WIDTH'($urandom);
                ClearR_LoadQ = (edges == 3) ? 1'b1 : 1'($urandom);
                if (edges == 3) Din = 8'h55;
            end
            tick();
            edges++;
        end
        ClearR_LoadQ = 1'b0;
        check({tag, ".latency"}, edges, (d == 0) ? 1 : 2 * WIDTH + 1);
        check({tag, ".busy_cycles"}, busy_cycles, (d == 0) ? 0 : 2 * WIDTH);
        check({tag, ".done"}, 32'(Done), 1);
        check_results(tag);
        for (int i = 0; i < int'(hold); i++) begin
            tick();
            check({tag, ".hold_done"}, 32'(Done), 1);
            check({tag, ".hold_quot"}, 32'(Quotient), m_q);
        end
        Execute = 1'b0;
        tick();
        check({tag, ".idle_done"}, 32'(Done), 0);
        check({tag, ".idle_busy"}, 32'(Busy), 0);
        check_results({tag, ".idle"});
    endtask

    initial begin
        Reset        = 1'b1;
        Execute      = 1'b0;
        ClearR_LoadQ = 1'b0;
        Din          = '0;
        tick();
        tick();
        Reset = 1'b0;
        check("reset.quot", 32'(Quotient), 0);
        check("reset.rem", 32'(Remainder), 0);
        check("reset.busy", 32'(Busy), 0);
        check("reset.done", 32'(Done), 0);
        check("reset.dbz", 32'(DivByZero), 0);

        load(100);
        check_results("load100");
        divide("100div7", 7, 2, 1'b0);

        load(255);
        divide("255div1", 1, 0, 1'b0);
        load(3);
        divide("3div200", 200, 0, 1'b0);

        load(5);
        divide("5div0", 0, 1, 1'b0);
        load(9);
        divide("9div4_clears_dbz", 4, 0, 1'b0);

        load(200);
        divide("200div16_held", 16, 40, 1'b0);
        divide("chain12div3", 3, 0, 1'b0);

        // Simultaneous load and Execute: load ignored
        load(50);
        ClearR_LoadQ = 1'b1;
        divide("exec_beats_load", 5, 0, 1'b0);

        // Reset in the middle of an iteration
        load(200);
        Execute = 1'b1;
        Din     = 8'd16;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("midrun.busy", 32'(Busy), 1);
        Execute = 1'b0;
        Reset   = 1'b1;
        tick();
        Reset = 1'b0;
        m_q   = 0;
        m_r   = 0;
        m_dbz = 0;
        check("midreset.busy", 32'(Busy), 0);
        check("midreset.done", 32'(Done), 0);
        check_results("midreset");
        divide("zero_div3", 3, 0, 1'b0);

        // Input disturbance while busy
        load(200);
        divide("200div16_disturbed", 16, 0, 1'b1);

        // Random divides, including occasional zero divisors and chained runs
        for (int n = 0; n < 30; n++) begin
            int unsigned d;
            if ($urandom_range(3) != 0) load($urandom_range(255));
            d = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
            divide("rand", d, $urandom_range(3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
